// File: rtl/seq_detect_pkg.sv
// Shared constants and helpers for the parametrised serial pattern detector.
package seq_detect_pkg;

    localparam logic OVL_ON  = 1'b1;
    localparam logic OVL_OFF = 1'b0;

    // Saturating increment for any counter up to 64 bits wide.
    function automatic logic [63:0] sat_inc(input logic [63:0] val, input int unsigned width);
        logic [63:0] max_v;
        max_v = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
        return (val == max_v) ? val : val + 64'd1;
    endfunction

endpackage

// File: rtl/seq_hist_reg.sv
// Serial history shift register with a saturating count of bits received since the last clear.
module seq_hist_reg
    import seq_detect_pkg::*;
#(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en_i,
    input  logic             bit_i,
    input  logic             clr_i,
    output logic [PAT_W-1:0] hist_o,
    output logic             full_o
);

    localparam int FW = $clog2(PAT_W + 1);

    logic [PAT_W-1:0] hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d;

    // Clear wins over shift so a non-overlap hit restarts the window cleanly.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (clr_i) begin
            hist_d = '0;
            fill_d = '0;
        end else if (shift_en_i) begin
            hist_d = {hist_q[PAT_W-2:0], bit_i};
            if (fill_q < FW'(PAT_W)) begin
                fill_d = fill_q + FW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

    assign hist_o = hist_q;
    // High when the next shifted-in bit completes a window of real received bits.
    assign full_o = (fill_q >= FW'(PAT_W - 1));

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised serial bit-pattern detector with runtime pattern/mode, registered match
// pulse and saturating match counter.
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter int               CNT_W   = 8,
    parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(4'b1010)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
    input  logic             cnt_clr,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    // Stream qualifier: in_bit is consumed on an edge only when in_valid=1 and
    // cfg_load=0; there is no back-pressure, every qualified bit is taken.

    logic [PAT_W-1:0] pattern_q, pattern_d;
    logic             overlap_q, overlap_d;
    logic             match_q, match_d;
    logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
    logic             cnt_sat_q, cnt_sat_d;

    logic [PAT_W-1:0] hist;
    logic             hist_full;
    logic [PAT_W-1:0] next_hist;
    logic             take_bit;
    logic             hit;
    logic             hist_clr;
    logic             unused_hist_msb;

    assign take_bit        = in_valid && !cfg_load;
    assign next_hist       = {hist[PAT_W-2:0], in_bit};
    assign hit             = take_bit && hist_full && (next_hist == pattern_q);
    assign hist_clr        = cfg_load || (hit && (overlap_q == OVL_OFF));
    assign unused_hist_msb = hist[PAT_W-1];

    seq_hist_reg #(
        .PAT_W (PAT_W)
    ) u_hist (
        .clk        (clk),
        .rst        (rst),
        .shift_en_i (take_bit),
        .bit_i      (in_bit),
        .clr_i      (hist_clr),
        .hist_o     (hist),
        .full_o     (hist_full)
    );

    always_comb begin
        pattern_d   = pattern_q;
        overlap_d   = overlap_q;
        match_d     = hit;
        match_cnt_d = match_cnt_q;
        if (cfg_load) begin
            pattern_d = cfg_pattern;
            overlap_d = cfg_overlap;
        end
        // A coincident clear beats the increment; the match pulse is unaffected.
        if (cnt_clr) begin
            match_cnt_d = '0;
        end else if (hit) begin
            match_cnt_d = CNT_W'(sat_inc(64'(match_cnt_q), CNT_W));
        end
        cnt_sat_d = (match_cnt_d == {CNT_W{1'b1}});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_q   <= RST_PAT;
            overlap_q   <= OVL_ON;
            match_q     <= 1'b0;
            match_cnt_q <= '0;
            cnt_sat_q   <= 1'b0;
        end else begin
            pattern_q   <= pattern_d;
            overlap_q   <= overlap_d;
            match_q     <= match_d;
            match_cnt_q <= match_cnt_d;
            cnt_sat_q   <= cnt_sat_d;
        end
    end

    assign match     = match_q;
    assign match_cnt = match_cnt_q;
    assign cnt_sat   = cnt_sat_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: two instances (4-bit/8-bit counter and 2-bit/2-bit counter)
// share one stimulus stream and are checked against a bit-list reference model.
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       cfg_load = 1'b0;
    logic [3:0] cfg_pattern_a = 4'h0;
    logic [1:0] cfg_pattern_b = 2'h0;
    logic       cfg_overlap = 1'b1;
    logic       cnt_clr = 1'b0;

    logic       match_a, cnt_sat_a;
    logic [7:0] match_cnt_a;
    logic       match_b, cnt_sat_b;
    logic [1:0] match_cnt_b;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state: bits received since the last clear, plus config
    bit         rxa_q[$];
    bit         rxb_q[$];
    logic [3:0] pat_a;
    logic [1:0] pat_b;
    logic       ovl_a, ovl_b;
    int         cnt_a, cnt_b;
    logic       em_a, em_b;

    always #5 clk = ~clk;

    seq_detect_param #(.PAT_W(4), .CNT_W(8), .RST_PAT(4'b1010)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern_a), .cfg_overlap(cfg_overlap),
        .cnt_clr(cnt_clr), .match(match_a), .match_cnt(match_cnt_a), .cnt_sat(cnt_sat_a)
    );

    seq_detect_param #(.PAT_W(2), .CNT_W(2), .RST_PAT(2'b11)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern_b), .cfg_overlap(cfg_overlap),
        .cnt_clr(cnt_clr), .match(match_b), .match_cnt(match_cnt_b), .cnt_sat(cnt_sat_b)
    );

    // True when the last w received bits, oldest first, spell pat from its MSB down.
    function automatic bit win_hit(input bit q[$], input int w, input logic [31:0] pat);
        int n;
        n = q.size();
        if (n < w) return 1'b0;
        for (int i = 0; i < w; i++) begin
            if (q[n - w + i] != pat[w - 1 - i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_edge();
        bit hit_a, hit_b;
        hit_a = 1'b0;
        hit_b = 1'b0;
        em_a  = 1'b0;
        em_b  = 1'b0;
        if (rst) begin
            rxa_q.delete(); rxb_q.delete();
            pat_a = 4'b1010; pat_b = 2'b11;
            ovl_a = 1'b1;    ovl_b = 1'b1;
            cnt_a = 0;       cnt_b = 0;
        end else begin
            if (cfg_load) begin
                rxa_q.delete(); rxb_q.delete();
                pat_a = cfg_pattern_a; pat_b = cfg_pattern_b;
                ovl_a = cfg_overlap;   ovl_b = cfg_overlap;
            end else if (in_valid) begin
                rxa_q.push_back(in_bit);
                rxb_q.push_back(in_bit);
                hit_a = win_hit(rxa_q, 4, 32'(pat_a));
                hit_b = win_hit(rxb_q, 2, 32'(pat_b));
                if (hit_a && !ovl_a) rxa_q.delete();
                if (hit_b && !ovl_b) rxb_q.delete();
                if (rxa_q.size() > 40) void'(rxa_q.pop_front());
                if (rxb_q.size() > 40) void'(rxb_q.pop_front());
            end
            em_a = hit_a;
            em_b = hit_b;
            if (cnt_clr) begin
                cnt_a = 0;
                cnt_b = 0;
            end else begin
                if (hit_a && cnt_a < 255) cnt_a++;
                if (hit_b && cnt_b < 3) cnt_b++;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic b, input logic ld,
                        input logic [3:0] pat, input logic ovl, input logic clr, input string tag);
        rst           = r;
        in_valid      = v;
        in_bit        = b;
        cfg_load      = ld;
        cfg_pattern_a = pat;
        cfg_pattern_b = pat[1:0];
        cfg_overlap   = ovl;
        cnt_clr       = clr;
        @(posedge clk);
        model_edge();
        #1;
        chk({tag, ".a.match"}, 32'(match_a), 32'(em_a));
        chk({tag, ".a.cnt"},   32'(match_cnt_a), 32'(cnt_a));
        chk({tag, ".a.sat"},   32'(cnt_sat_a), 32'(cnt_a == 255));
        chk({tag, ".b.match"}, 32'(match_b), 32'(em_b));
        chk({tag, ".b.cnt"},   32'(match_cnt_b), 32'(cnt_b));
        chk({tag, ".b.sat"},   32'(cnt_sat_b), 32'(cnt_b == 3));
    endtask

    task automatic send(input logic b, input string tag);
        step(1'b0, 1'b1, b, 1'b0, 4'h0, 1'b1, 1'b0, tag);
    endtask

    task automatic idle(input string tag);
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, tag);
    endtask

    task automatic load(input logic [3:0] pat, input logic ovl, input string tag);
        step(1'b0, 1'b0, 1'b0, 1'b1, pat, ovl, 1'b0, tag);
    endtask

    initial begin
        logic [7:0] stream;
        stream = 8'b1010_1010;

        // reset state
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, "rst0");
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, "rst1");

        // overlap mode, 10101010
        for (int i = 7; i >= 0; i--) send(stream[i], "ovl");

        // non-overlap mode, same stream after clearing the counter
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, "clr");
        load(4'b1010, 1'b0, "ld_novl");
        for (int i = 7; i >= 0; i--) send(stream[i], "novl");

        // valid gaps do not disturb history
        load(4'b1010, 1'b1, "ld_gap");
        send(1'b1, "gap");
        send(1'b0, "gap");
        for (int i = 0; i < 3; i++) idle("gap_idle");
        send(1'b1, "gap");
        send(1'b0, "gap");

        // saturation: pattern 1111/11, seven ones
        load(4'b1111, 1'b1, "ld_sat");
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, "clr_sat");
        for (int i = 0; i < 7; i++) send(1'b1, "sat");

        // cnt_clr coincident with a hit
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, "clr_hit");

        // reset mid-pattern
        load(4'b1010, 1'b1, "ld_rst");
        send(1'b1, "pre_rst");
        send(1'b0, "pre_rst");
        send(1'b1, "pre_rst");
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, "mid_rst");
        send(1'b0, "post_rst");

        // all-zero pattern loaded while a valid zero is presented
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, "ld_zero");
        for (int i = 0; i < 4; i++) send(1'b0, "zeros");

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(59, 0) == 0),
                 ($urandom_range(3, 0) != 0),
                 1'($urandom_range(1, 0)),
                 ($urandom_range(24, 0) == 0),
                 4'($urandom_range(15, 0)),
                 1'($urandom_range(1, 0)),
                 ($urandom_range(19, 0) == 0),
                 "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
Parametrised serial bit-pattern detector, the successor to the fixed 4-bit Mealy sequence detectors.
- Pattern width is a parameter; pattern value is runtime-loadable.
- Runtime-selectable overlapping or non-overlapping detection.
- Input is valid-qualified; registered one-cycle match pulse plus a saturating match counter.
- Sits on a serial data stream feeding framing/sync logic.

Parameters:
PAT_W, 4, pattern length in bits (2..32).
CNT_W, 8, match counter width (>=1).
RST_PAT, 4'b1010 (sized to PAT_W), pattern value after reset.

Ports:
clk  input  1  clock, all logic on rising edge.
rst  input  1  synchronous active-high reset.
in_valid  input  1  in_bit is sampled only when high.
in_bit  input  1  serial data bit.
cfg_load  input  1  load cfg_pattern and cfg_overlap; clears history.
cfg_pattern  input  PAT_W  new pattern; bit PAT_W-1 is the first bit received.
cfg_overlap  input  1  1 = overlapping, 0 = non-overlapping.
cnt_clr  input  1  clear match counter.
match  output  1  one-cycle pulse on detection.
match_cnt  output  CNT_W  saturating count of matches.
cnt_sat  output  1  high while match_cnt is all-ones.

Behaviour:
- Reset (rst=1 at an edge) overrides everything and takes priority over all other inputs:
  - history=0, fill=0, pattern=RST_PAT, overlap=1, match=0, match_cnt=0, cnt_sat=0.
- State:
  - history: PAT_W-bit shift register; newest bit enters at the LSB.
  - fill: count of valid bits since the last clear, saturating at PAT_W.
- On an edge with in_valid=1 and cfg_load=0:
  - next_hist = {history[PAT_W-2:0], in_bit}.
  - hit = (fill+1 >= PAT_W) and (next_hist == pattern).
  - Overlap mode: history<=next_hist, fill<=min(fill+1, PAT_W).
  - Non-overlap mode on hit: history<=0, fill<=0; otherwise same as overlap mode.
- match is registered: match<=hit. It goes high in the cycle after the final pattern bit is sampled, for exactly one cycle.
- match is 0 after any edge where in_valid=0. Gaps in in_valid do not disturb history or fill.
- match_cnt increments on hit unless already all-ones (saturates, no wrap).
- cnt_sat is registered and equals (match_cnt == all-ones).
- cnt_clr:
  - match_cnt<=0.
  - If a hit occurs on the same edge, cnt_clr wins and the count stays 0; match still pulses.
- cfg_load has priority over in_valid:
  - Latches pattern and overlap mode, clears history and fill, sets match<=0.
  - Any bit presented on that edge is discarded.
  - match_cnt is unaffected.
- The first match is possible only after PAT_W valid bits since reset, cfg_load, or a non-overlap clear. Leading zeros in history never count as received bits.
- Pattern of all zeros: detected only after PAT_W real zero bits (fill guard).
- Mode change takes effect only through cfg_load, never mid-stream.

Decomposition:
- Package seq_detect_pkg holds:
  - the overlap/non-overlap mode constants (OVL_ON=1'b1, OVL_OFF=1'b0);
  - a function for the saturating increment.
- One sub-module, seq_hist_reg (PAT_W):
  - Contains the history shift register and fill counter.
  - Inputs: shift enable, bit, clear.
  - Outputs: history, full flag.
- The top level contains compare, match register, counter and config registers.

Test Plan:
- Overlap mode, pattern 1010, PAT_W=4, in_valid=1, stream 1,0,1,0,1,0,1,0 -> match pulses after bits 4, 6, 8; match_cnt=3.
- Non-overlap mode (cfg_load with cfg_overlap=0), same stream -> match after bits 4 and 8 only; match_cnt=2.
- Overlap mode, stream 1,0,(in_valid=0 for 3 cycles),1,0 -> single match one cycle after the last 0; no match during the gap.
- CNT_W=2, pattern 11, overlap, stream of seven 1s -> hits=6; match_cnt goes 1,2,3 then holds 3; cnt_sat=1.
- cnt_clr coincident with a hit -> match=1, match_cnt=0. rst asserted after bits 1,0,1 -> next bit 0 gives no match; all outputs 0 the cycle after reset.
- cfg_load pattern 0000 at the same edge as in_valid=1 with in_bit=0 -> that bit is discarded. Then three zeros -> no match; fourth zero -> match.
